// File: rtl/fetch_queue_pkg.sv
// Shared decode/pipeline definitions used by the fetch queue.
//   - Entry field widths (PC, instruction, fault) and total entry width.
//   - fq_entry_t: packed layout of one queue entry as held in storage.
//   - decode_inst_t: bundle handed from the fetch queue head into decode.
//   - make_entry(): builds a storage entry from raw fetch outputs.
package fetch_queue_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INST_W  = 32;
    localparam int unsigned FAULT_W = 1;
    localparam int unsigned ENTRY_W = PC_W + INST_W + FAULT_W;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INST_W-1:0]  inst;
        logic [FAULT_W-1:0] fault;
    } fq_entry_t;

    typedef struct packed {
        logic [INST_W-1:0]  instruction;
        logic [PC_W-1:0]    pc;
        logic [FAULT_W-1:0] fault;
    } decode_inst_t;

    // A faulted fetch carries no meaningful instruction, so it is stored as
    // zero to keep garbage from ever reaching decode.
    function automatic fq_entry_t make_entry(input logic [PC_W-1:0]    pc,
                                             input logic [INST_W-1:0]  inst,
                                             input logic [FAULT_W-1:0] fault);
        fq_entry_t e;
        e.pc    = {pc[PC_W-1:2], 2'b00};
        e.inst  = (fault != '0) ? '0 : inst;
        e.fault = fault;
        return e;
    endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: DEPTH x ENTRY_W bits.
// Synchronous write, asynchronous read, no reset (contents are only
// observed after being written).
//   clk      - clock
//   wr_en    - write wr_data into wr_addr on the rising edge
//   wr_addr  - write index
//   wr_data  - entry to store
//   rd_addr  - read index
//   rd_data  - entry at rd_addr (combinational)
module fetch_queue_mem
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [ENTRY_W-1:0] rd_data
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue between instruction fetch and decode.
// Valid/ready FIFO of (pc, inst, fault) entries with flush.
//   clk, reset_n         - clock, async active-low reset
//   flush                - drop all entries (redirect/exception), highest priority
//   in_valid/in_ready    - push handshake; in_ready depends on registered state only
//   in_pc/in_inst/in_fault - pushed entry; faulted pushes store inst as zero
//   out_valid/out_ready  - pop handshake; out_valid = (count != 0)
//   out_pc/out_inst/out_fault - head entry; hold last shown value while empty
//   count                - occupancy 0..DEPTH
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    input  logic              in_fault,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic              out_fault,
    output logic [AW:0]       count
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    // Holds in_ready low until the first edge after reset release.
    logic          started_q;

    logic          full, empty, push, pop;
    fq_entry_t     wr_entry, rd_entry, hold_q, out_entry;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign in_ready  = started_q && !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign count     = count_q;

    assign wr_entry = make_entry(in_pc, in_inst, in_fault);

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (tail_q),
        .wr_data (wr_entry),
        .rd_addr (head_q),
        .rd_data (rd_entry)
    );

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + 1'b1;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            started_q <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            started_q <= 1'b1;
        end
    end

    // Once the queue drains, the head slot may hold stale data, so remember
    // the last entry shown and keep presenting it while empty.
    always_ff @(posedge clk) begin
        if (out_valid) begin
            hold_q <= rd_entry;
        end
    end

    assign out_entry = out_valid ? rd_entry : hold_q;
    assign out_pc    = out_entry.pc;
    assign out_inst  = out_entry.inst;
    assign out_fault = out_entry.fault;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic,
// checked by a queue-based reference model and scoreboard.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_pc = '0;
    logic [31:0]   in_inst = '0;
    logic          in_fault = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_pc;
    logic [31:0]   out_inst;
    logic          out_fault;
    logic [AW:0]   count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    exp_t exp_q[$];
    bit   rdy_m;

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .in_fault  (in_fault),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .out_fault (out_fault),
        .count     (count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the queue accepts only from the first edge after reset release.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) rdy_m <= 1'b0;
        else          rdy_m <= 1'b1;
    end

    always @(negedge reset_n) exp_q.delete();

    // Scoreboard: compare status and head entry, then retire/accept per the
    // handshake the upcoming edge will perform.
    always @(negedge clk) begin : scoreboard
        bit   exp_valid;
        bit   exp_ready;
        exp_t e;
        if (!reset_n) begin
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_count", 32'(count), 32'd0);
        end else begin
            exp_valid = (exp_q.size() != 0);
            exp_ready = rdy_m && (exp_q.size() != DEPTH);
            chk("count", 32'(count), 32'(exp_q.size()));
            chk("in_ready", 32'(in_ready), 32'(exp_ready));
            chk("out_valid", 32'(out_valid), 32'(exp_valid));
            if (exp_valid && out_valid) begin
                chk("out_pc", out_pc, exp_q[0].pc);
                chk("out_inst", out_inst, exp_q[0].inst);
                chk("out_fault", 32'(out_fault), 32'(exp_q[0].fault));
            end
            if (flush) begin
                exp_q.delete();
            end else begin
                if (exp_valid && out_ready) void'(exp_q.pop_front());
                if (in_valid && exp_ready) begin
                    e.pc    = in_pc & ~32'h3;
                    e.inst  = in_fault ? 32'h0 : in_inst;
                    e.fault = in_fault;
                    exp_q.push_back(e);
                end
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic f, input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst;
        in_fault  = f;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        idle();
    endtask

    initial begin
        // Reset and first push.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready_low", 32'(in_ready), 32'd0);
        reset_n = 1'b1;
        #2;
        chk("in_ready_before_edge", 32'(in_ready), 32'd0);
        step(1'b1, 32'h100, 32'h918b0040, 1'b0, 1'b0, 1'b0);
        idle();
        #2;
        chk("first_count", 32'(count), 32'd1);
        chk("first_out_valid", 32'(out_valid), 32'd1);
        chk("first_out_pc", out_pc, 32'h100);
        chk("first_out_inst", out_inst, 32'h918b0040);
        drain(1);

        // Fill to full, reject a fifth, pop one.
        for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + 32'(4 * i), $urandom, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h110, 32'hdeadbeef, 1'b0, 1'b0, 1'b0);
        #2;
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        idle();
        #2;
        chk("after_pop_in_ready", 32'(in_ready), 32'd1);
        chk("after_pop_count", 32'(count), 32'd3);
        chk("after_pop_head", out_pc, 32'h104);
        drain(3);

        // Steady stream at occupancy 2.
        step(1'b1, 32'h500, $urandom, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h504, $urandom, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 32'h508 + 32'(4 * i), $urandom, 1'b0, 1'b1, 1'b0);
        idle();
        #2;
        chk("stream_count", 32'(count), 32'd2);
        chk("stream_head", out_pc, 32'h550);
        drain(2);

        // Faulted fetch.
        step(1'b1, 32'h200, 32'h7d4802a6, 1'b1, 1'b0, 1'b0);
        idle();
        #2;
        chk("fault_bit", 32'(out_fault), 32'd1);
        chk("fault_inst", out_inst, 32'h0);
        drain(1);

        // Flush at count 3 with push and pop requested.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h600 + 32'(4 * i), $urandom, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h700, $urandom, 1'b0, 1'b1, 1'b1);
        step(1'b1, 32'h300, 32'h12345678, 1'b0, 1'b0, 1'b0);
        #2;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        idle();
        #2;
        chk("post_flush_head", out_pc, 32'h300);
        drain(1);

        // Asynchronous reset mid-operation.
        step(1'b1, 32'h800, $urandom, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h804, $urandom, 1'b0, 1'b0, 1'b0);
        idle();
        #2;
        chk("pre_rst_count", 32'(count), 32'd2);
        reset_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_count", 32'(count), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(1'b1, 32'h900, 32'hcafef00d, 1'b0, 1'b0, 1'b0);
        idle();
        #2;
        chk("post_rst_head", out_pc, 32'h900);
        chk("post_rst_count", 32'(count), 32'd1);
        drain(1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, $urandom,
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 31) == 0));
        end
        drain(DEPTH + 1);
        #2;
        chk("final_count", 32'(count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
